// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM download router: FSM states, the queued write entry
// and the byte-address to word/lane mapping used by every port.
package rom_dl_pkg;

    localparam int DL_AW = 24;

    typedef enum logic [1:0] {
        IDLE,
        LOADING,
        DRAINING,
        DONE
    } dl_state_t;

    typedef struct packed {
        logic [DL_AW-1:0] a;
        logic [1:0]       ds;
        logic [7:0]       data;
    } dl_entry_t;

    // Word bits below the lane bit stay in place; bits above shift down by one.
    // With mb == 0 this is the plain off[24:1] / off[0] mapping.
    function automatic dl_entry_t map_addr(input logic [24:0] off,
                                           input logic [4:0]  mb,
                                           input logic [7:0]  data);
        dl_entry_t e;
        e.a = '0;
        for (int i = 0; i < DL_AW; i++) begin
            e.a[i] = (i < int'(mb)) ? off[i] : off[i+1];
        end
        e.ds   = {off[mb], ~off[mb]};
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/dl_fifo.sv
// Per-port synchronous FIFO of pending SDRAM writes. A push on a full FIFO is
// still taken when the same cycle pops; otherwise it is dropped and flagged.
module dl_fifo
    import rom_dl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      reset_i,
    input  logic      push_i,
    input  dl_entry_t wdata_i,
    input  logic      pop_i,
    output dl_entry_t rdata_o,
    output logic      full_o,
    output logic      empty_o,
    output logic      drop_o
);

    localparam int PW = $clog2(DEPTH);

    dl_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && !do_push;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/rom_download_router.sv
// Routes data_io download bytes into per-port SDRAM write windows over toggle
// req/ack handshakes, and produces rom_loaded / core_reset for the arcade core.
module rom_download_router
    import rom_dl_pkg::*;
#(
    parameter int                    NPORTS     = 2,
    parameter int                    AW         = 23,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [7:0]            ROM_INDEX  = 8'd0,
    parameter logic [NPORTS*25-1:0]  BASE       = {25'h000C000, 25'h0000000},
    parameter logic [NPORTS*25-1:0]  LAST       = {25'h001FFFF, 25'h001FFFF},
    parameter logic [NPORTS*5-1:0]   MERGE_BIT  = {5'd13, 5'd0}
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ioctl_download,
    input  logic [7:0]           ioctl_index,
    input  logic                 ioctl_wr,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    input  logic                 reset_req,
    output logic [NPORTS-1:0]    port_req,
    input  logic [NPORTS-1:0]    port_ack,
    output logic [NPORTS*AW-1:0] port_a,
    output logic [NPORTS*2-1:0]  port_ds,
    output logic [NPORTS*16-1:0] port_d,
    output logic                 port_we,
    output logic                 rom_loaded,
    output logic                 core_reset,
    output logic                 overflow
);

    dl_state_t         state_q, state_d;
    logic              wr_q, dl_q;
    logic              stb_q;
    logic [24:0]       addr_q;
    logic [7:0]        data_q;
    logic              rom_loaded_q, core_reset_q, overflow_q;
    logic              idx_match, accept, dl_rise;
    logic [NPORTS-1:0] empty_v, idle_v, drop_v;

    assign idx_match = (ioctl_index == ROM_INDEX);
    assign accept    = ioctl_wr && !wr_q && ioctl_download && idx_match;
    assign dl_rise   = ioctl_download && !dl_q;

    // Captured byte is pushed into the matching windows on the following edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_q   <= 1'b0;
            dl_q   <= 1'b0;
            stb_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wr_q  <= ioctl_wr;
            dl_q  <= ioctl_download;
            stb_q <= accept;
            if (accept) begin
                addr_q <= ioctl_addr;
                data_q <= ioctl_dout;
            end
        end
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        localparam logic [24:0] PBASE = BASE[p*25 +: 25];
        localparam logic [24:0] PLAST = LAST[p*25 +: 25];
        localparam logic [4:0]  PMB   = MERGE_BIT[p*5 +: 5];

        logic          req_q;
        logic [AW-1:0] a_q;
        logic [1:0]    ds_q;
        logic [15:0]   d_q;
        logic          hit, pop, full;
        logic [24:0]   off;
        dl_entry_t     entry, head;

        assign off   = addr_q - PBASE;
        assign hit   = stb_q && (addr_q >= PBASE) && (addr_q <= PLAST);
        assign entry = map_addr(off, PMB, data_q);
        assign idle_v[p] = (req_q == port_ack[p]);
        assign pop   = idle_v[p] && !empty_v[p];

        dl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk_i   (clk_sys),
            .reset_i (reset),
            .push_i  (hit),
            .wdata_i (entry),
            .pop_i   (pop),
            .rdata_o (head),
            .full_o  (full),
            .empty_o (empty_v[p]),
            .drop_o  (drop_v[p])
        );

        // Request fields are loaded and req toggled on the same edge as the pop.
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                req_q <= 1'b0;
                a_q   <= '0;
                ds_q  <= '0;
                d_q   <= '0;
            end else if (pop) begin
                req_q <= ~req_q;
                a_q   <= AW'(head.a);
                ds_q  <= head.ds;
                d_q   <= {head.data, head.data};
            end
        end

        assign port_req[p]           = req_q;
        assign port_a[p*AW +: AW]    = a_q;
        assign port_ds[p*2 +: 2]     = ds_q;
        assign port_d[p*16 +: 16]    = d_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (dl_rise && idx_match) state_d = LOADING;
            LOADING:  if (!ioctl_download) state_d = DRAINING;
            DRAINING: begin
                if (ioctl_download && idx_match)
                    state_d = LOADING;
                else if (!stb_q && (&empty_v) && (&idle_v))
                    state_d = DONE;
            end
            DONE:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= IDLE;
            rom_loaded_q <= 1'b0;
            overflow_q   <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            if (state_q == DONE) rom_loaded_q <= 1'b1;
            if (|drop_v) overflow_q <= 1'b1;
            core_reset_q <= reset_req || !rom_loaded_q;
        end
    end

    assign port_we    = ioctl_download;
    assign rom_loaded = rom_loaded_q;
    assign core_reset = core_reset_q;
    assign overflow   = overflow_q;

endmodule
